traffic_light_ctrl: RTL

//  Six-phase traffic-light sequencer for a main/side road crossing, clocked by clk_50MHz.

---
 rtl/tlc_pkg.sv | 56 +++++
 rtl/tick_strobe.sv | 27 ++
 rtl/traffic_light_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared phase encoding, lamp patterns and phase sequencing for the traffic-light controller.
// FLASH is only reachable when TLC_NIGHT_FLASH_EN is defined.
package tlc_pkg;

  localparam logic [2:0] AR_A  = 3'd0;
  localparam logic [2:0] MG    = 3'd1;
  localparam logic [2:0] MY    = 3'd2;
  localparam logic [2:0] AR_B  = 3'd3;
  localparam logic [2:0] SG    = 3'd4;
  localparam logic [2:0] SY    = 3'd5;
  localparam logic [2:0] FLASH = 3'd6;

  localparam logic [2:0] RGY_RED = 3'b100;
  localparam logic [2:0] RGY_YEL = 3'b010;
  localparam logic [2:0] RGY_GRN = 3'b001;
  localparam logic [2:0] RGY_OFF = 3'b000;

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    logic [2:0] nx;
    nx = AR_A;
    case (ph)
      AR_A:    nx = MG;
      MG:      nx = MY;
      MY:      nx = AR_B;
      AR_B:    nx = SG;
      SG:      nx = SY;
      default: nx = AR_A;
    endcase
    return nx;
  endfunction

  // FLASH starts with its lit half: main yellow, side red.
  function automatic logic [2:0] main_lamp(input logic [2:0] ph);
    logic [2:0] l;
    l = RGY_RED;
    case (ph)
      MG:      l = RGY_GRN;
      MY:      l = RGY_YEL;
      FLASH:   l = RGY_YEL;
      default: l = RGY_RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] side_lamp(input logic [2:0] ph);
    logic [2:0] l;
    l = RGY_RED;
    case (ph)
      SG:      l = RGY_GRN;
      SY:      l = RGY_YEL;
      default: l = RGY_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_strobe.sv
// One-cycle enable every CLK_HZ clocks, replacing a derived divider clock.
module tick_strobe #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk_50MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST     = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLK_HZ - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CW'(1);
      // Registered one cycle early so tick is high exactly while count == LAST.
      tick  <= (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase main/side crossing sequencer with pedestrian cut and walk lamp.
// Define TLC_NIGHT_FLASH_EN to add the night_mode input and the FLASH phase.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned T_MG   = 30,
  parameter int unsigned T_MY   = 3,
  parameter int unsigned T_AR   = 1,
  parameter int unsigned T_SG   = 15,
  parameter int unsigned T_SY   = 3,
  parameter int unsigned T_PED  = 5
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       ped_req,
`ifdef TLC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic [7:0] countdown,
  output logic       tick
);

  localparam logic [7:0] TS_MG  = 8'(T_MG);
  localparam logic [7:0] TS_MY  = 8'(T_MY);
  localparam logic [7:0] TS_AR  = 8'(T_AR);
  localparam logic [7:0] TS_SG  = 8'(T_SG);
  localparam logic [7:0] TS_SY  = 8'(T_SY);
  localparam logic [7:0] TS_PED = 8'(T_PED);

  function automatic logic [7:0] phase_time(input logic [2:0] ph);
    logic [7:0] t;
    t = 8'd0;
    case (ph)
      AR_A, AR_B: t = TS_AR;
      MG:         t = TS_MG;
      MY:         t = TS_MY;
      SG:         t = TS_SG;
      SY:         t = TS_SY;
      default:    t = 8'd0;
    endcase
    return t;
  endfunction

  logic [2:0] phase;
  logic [2:0] nxt_phase;
  logic [7:0] nxt_cd;
  logic       enter;
  logic       ped_pending;

  tick_strobe #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .tick      (tick)
  );

  always_comb begin
    nxt_phase = phase;
    nxt_cd    = countdown;
    enter     = 1'b0;
    if (tick) begin
`ifdef TLC_NIGHT_FLASH_EN
      if (phase == FLASH) begin
        if (!night_mode) begin
          nxt_phase = AR_A;
          nxt_cd    = TS_AR;
          enter     = 1'b1;
        end
      end else
`endif
      if (phase == MG && ped_pending && countdown > TS_PED) begin
        nxt_cd = TS_PED;
      end else if (countdown == 8'd1) begin
        nxt_phase = next_phase(phase);
`ifdef TLC_NIGHT_FLASH_EN
        if (night_mode && (phase == AR_A || phase == AR_B)) nxt_phase = FLASH;
`endif
        nxt_cd = phase_time(nxt_phase);
        enter  = 1'b1;
      end else begin
        nxt_cd = countdown - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      phase       <= AR_A;
      countdown   <= TS_AR;
      main_rgy    <= RGY_RED;
      side_rgy    <= RGY_RED;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      phase     <= nxt_phase;
      countdown <= nxt_cd;
      // A press in the same cycle that enters SG survives for the next round.
      ped_pending <= ped_req | (ped_pending & ~(enter & (nxt_phase == SG)));
      if (enter) begin
        main_rgy <= main_lamp(nxt_phase);
        side_rgy <= side_lamp(nxt_phase);
        walk     <= (nxt_phase == SG) & (ped_pending | ped_req);
      end
`ifdef TLC_NIGHT_FLASH_EN
      else if (tick && phase == FLASH) begin
        main_rgy <= (main_rgy == RGY_YEL) ? RGY_OFF : RGY_YEL;
        side_rgy <= (side_rgy == RGY_RED) ? RGY_OFF : RGY_RED;
      end
`endif
    end
  end

endmodule
